// File: rtl/alu_pkg.sv
// Shared types for the ALU front end: opcode, driver FSM state and default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] opcode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/alu_driver_if.sv
// Command and response handshakes of alu_driver.
// With ALU_DRIVER_ZFLAG_EN defined, the response side also carries rsp_zero.
interface alu_driver_if #(
  parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
) ();
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  opcode_t          cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  opcode_t          rsp_opcode;
`ifdef ALU_DRIVER_ZFLAG_EN
  logic             rsp_zero;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_opcode, rsp_zero
  );
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_opcode, rsp_zero
  );
`else
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_opcode
  );
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_opcode
  );
`endif

endinterface

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with a registered head word, occupancy count and full/empty.
// A pushed word first appears on head the cycle after the push edge.
module alu_rsp_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [DW-1:0] head_reg, head_next;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && (count_reg != FULL_CNT);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    count_next  = count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_next   = head_reg;
    // The incoming word becomes head when nothing older will remain after this edge.
    if (do_push && ((count_reg == '0) || ((count_reg == (AW+1)'(1)) && do_pop))) begin
      head_next = push_data;
    end else if (do_pop && (count_reg > (AW+1)'(1))) begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign head  = head_reg;
  assign count = count_reg;
  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

endmodule

// File: rtl/alu_driver.sv
// Clocked initiator for the 2-bit-opcode combinational ALU: registers operands, waits SETTLE
// cycles, then queues {opcode, result}. Optional macro ALU_DRIVER_ZFLAG_EN adds a zero flag.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 1,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_driver_if.slave      bus,
  output opcode_t          alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
`ifdef ALU_DRIVER_ZFLAG_EN
  localparam int DW = WIDTH + 3;
`else
  localparam int DW = WIDTH + 2;
`endif

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  opcode_t          opcode_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             cmd_ready_c, busy_c, push_c, accept;
  logic [DW-1:0]    push_data, head;
  logic [AW:0]      fifo_count;
  logic             fifo_full, fifo_empty;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    cmd_ready_c = 1'b0;
    busy_c      = 1'b0;
    push_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready_c = (fifo_count < (AW+1)'(DEPTH));
        if (bus.cmd_valid && cmd_ready_c) begin
          state_next = DRIVE;
          cnt_next   = CW'(SETTLE - 1);
        end
      end
      DRIVE: begin
        busy_c = 1'b1;
        if (cnt_reg == '0) begin
          push_c     = !fifo_full;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state_reg == IDLE) && bus.cmd_valid && cmd_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      opcode_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        opcode_reg <= bus.cmd_opcode;
        a_reg      <= bus.cmd_a;
        b_reg      <= bus.cmd_b;
      end
    end
  end

`ifdef ALU_DRIVER_ZFLAG_EN
  assign push_data = {(alu_out == '0), opcode_reg, alu_out};
`else
  assign push_data = {opcode_reg, alu_out};
`endif

  alu_rsp_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_data),
    .pop       (bus.rsp_ready),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.rsp_valid  = !fifo_empty;
  assign bus.rsp_data   = head[WIDTH-1:0];
  assign bus.rsp_opcode = head[WIDTH+1:WIDTH];
`ifdef ALU_DRIVER_ZFLAG_EN
  assign bus.rsp_zero   = head[WIDTH+2];
`endif

  assign alu_opcode = opcode_reg;
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign busy       = busy_c;

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequential front end for the 2-bit-opcode, 8-bit combinational ALU. Accepts operation commands over a valid/ready handshake and drives the ALU's opcode/A/B inputs from registers. After a programmable settle time it samples the ALU result and queues it in a small response buffer drained by a second valid/ready handshake. It replaces free-running stimulus with a clocked initiator, so the ALU can sit inside synchronous datapaths.

## Interface
- WIDTH, 8, operand/result width
- SETTLE, 1, cycles operands are held before the result is sampled (≥1)
- DEPTH, 4, response buffer entries (power of 2, ≥2)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready at clk edge
- cmd_opcode  in  2  operation
- cmd_a, cmd_b  in  WIDTH  operands
- alu_opcode  out  2  registered, to ALU OPCODE
- alu_a, alu_b  out  WIDTH  registered, to ALU A/B
- alu_out  in  WIDTH  ALU OUT
- rsp_valid  out  1  response buffer non-empty
- rsp_ready  in  1  consumer pops on valid&&ready
- rsp_data  out  WIDTH  head result
- rsp_opcode  out  2  head opcode
- busy  out  1  command in flight (state DRIVE)

## Operation
- FSM states: IDLE, DRIVE.
- IDLE: cmd_ready = (count < DEPTH). On accept: load alu_opcode/alu_a/alu_b, settle counter = SETTLE-1, go to DRIVE.
- DRIVE: cmd_ready = 0, busy = 1. Counter decrements each cycle. On the edge where counter = 0: sample alu_out, push {opcode, result} into the buffer, return to IDLE.
- alu_* hold their last values in IDLE; the ALU output stays stable.
- The buffer cannot overflow. At most one command is in flight, and acceptance requires a free entry. No push ever occurs when full.
- Pop while empty: ignored. Simultaneous push and pop: both happen, count unchanged.
- No bypass. A pushed entry is visible on rsp_* the cycle after the push edge.
- Results are stored unmodified, truncated to WIDTH by the ALU.

## Timing
- Reset (async assert, sync-safe deassert by the system): state IDLE, alu_opcode/alu_a/alu_b = 0, buffer empty, rsp_valid = 0, rsp_data/rsp_opcode = 0, busy = 0. cmd_ready = 1 once out of reset.
- Accept at edge 0: alu_* valid after edge 0. Sample/push at edge SETTLE. rsp_valid high after edge SETTLE.
- Next accept is possible at edge SETTLE+1. Throughput is one command per SETTLE+1 cycles.
- Reset mid-DRIVE: the in-flight command is discarded, no response, buffer cleared.

## Configuration
- ALU_DRIVER_ZFLAG_EN defined: adds output rsp_zero (1 bit). It is stored per entry, set when the sampled result equals 0, reset value 0.
- Undefined: the port and storage bit are absent. Behaviour is otherwise identical.

## Structure
- Shared package alu_pkg:
  - opcode typedef (2-bit)
  - FSM state enum {IDLE, DRIVE}
  - default WIDTH constant
- Sub-module alu_rsp_fifo: DEPTH-entry synchronous FIFO with registered head outputs, count, and a full/empty pair. It is instantiated once.

## Test plan
- Bench ALU model: 00 add, 01 sub, 10 and, 11 or; SETTLE=1 unless noted.
- Reset: hold rst_n low mid-cycle -> all outputs 0 immediately, cmd_ready=1 after release, rsp_valid=0.
- Single command: op 00, A=3, B=2 -> alu_a=3/alu_b=2 after edge 0, rsp_valid after edge 1, rsp_data=5, rsp_opcode=00, busy high for exactly 1 cycle.
- Fill: rsp_ready=0, commands (01,7,2), (10,6,2), (11,6,2), (00,1,1) -> responses 5, 2, 6, 2 queued. A fifth command sees cmd_ready=0 until one pop, then it is accepted.
- Same-cycle push/pop with count=1: count stays 1, order preserved. SETTLE=3 -> rsp_valid 3 cycles after accept.
- Reset during DRIVE (SETTLE=3, assert at cycle 2) -> no response, buffer empty, alu_*=0.
- ZFLAG_EN: op 01, A=2, B=2 -> rsp_data=0, rsp_zero=1. Op 00, A=2, B=2 -> rsp_zero=0.
